column_sum_scheduler: RTL and testbench

Sequences one shared column-sum adder (3 x IEEE-754 single operands) across all NUM_COLS variable-node columns of the LDPC belief-propagation decoder. For each column it fetches the three check-to-variable messages from message memory, drives the adder with a start pulse, waits for done, and writes the sum to result memory. It sits between the message RAM, the column-sum adder and the iteration-level controller, which triggers one sweep per BP iteration.

---
 rtl/col_sum_pkg.sv | 23 ++
 rtl/column_sum_scheduler_if.sv | 32 +++
 rtl/column_sum_scheduler.sv | 131 +++++++++++++
 tb/tb_column_sum_scheduler.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/col_sum_pkg.sv
// Shared types and constants for the LDPC column-sum scheduler.
// The optional adder watchdog is enabled with COL_SUM_TIMEOUT_EN.
package col_sum_pkg;

  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] FLOAT_QNAN = 32'h7FC00000;

  // msg_rd_data is packed {r3, r2, r1}
  localparam int R1_LSB = 0;
  localparam int R2_LSB = 32;
  localparam int R3_LSB = 64;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    WAIT_RD  = 3'd2,
    LAUNCH   = 3'd3,
    WAIT_ADD = 3'd4,
    WRITE    = 3'd5,
    DONE     = 3'd6
  } state_t;

endpackage

// File: rtl/column_sum_scheduler_if.sv
// Bus bundle between the scheduler and message RAM, column-sum adder and result RAM.
// Shares the COL_SUM_TIMEOUT_EN build with the scheduler (no feature-specific signals here).
interface col_sum_if #(parameter int ADDR_W = 3);

  // msg_rd_data is valid exactly one cycle after msg_rd_en; add_start is a single-cycle
  // request, answered by add_done (with add_sum valid) only while the scheduler waits.
  logic                            msg_rd_en;
  logic [ADDR_W-1:0]               msg_rd_addr;
  logic [3*col_sum_pkg::DATA_W-1:0] msg_rd_data;
  logic [col_sum_pkg::DATA_W-1:0]  add_r1;
  logic [col_sum_pkg::DATA_W-1:0]  add_r2;
  logic [col_sum_pkg::DATA_W-1:0]  add_r3;
  logic                            add_start;
  logic                            add_done;
  logic [col_sum_pkg::DATA_W-1:0]  add_sum;
  logic                            res_wr_en;
  logic [ADDR_W-1:0]               res_wr_addr;
  logic [col_sum_pkg::DATA_W-1:0]  res_wr_data;

  modport master (
    output msg_rd_en, msg_rd_addr, add_r1, add_r2, add_r3, add_start,
           res_wr_en, res_wr_addr, res_wr_data,
    input  msg_rd_data, add_done, add_sum
  );

  modport slave (
    input  msg_rd_en, msg_rd_addr, add_r1, add_r2, add_r3, add_start,
           res_wr_en, res_wr_addr, res_wr_data,
    output msg_rd_data, add_done, add_sum
  );

endinterface

// File: rtl/column_sum_scheduler.sv
// Sweeps all NUM_COLS columns through one shared 3-operand float adder per BP iteration.
// Define COL_SUM_TIMEOUT_EN to add a WAIT_ADD watchdog that writes a quiet NaN and sets err.
module column_sum_scheduler
  import col_sum_pkg::*;
#(
  parameter int NUM_COLS = 8,
  parameter int ADDR_W   = 3,
  parameter int TIMEOUT  = 64
) (
  input  logic      clk,
  input  logic      clr_n,
  input  logic      go,
  output logic      busy,
  output logic      sweep_done,
  output logic      err,
  output state_t    state_dbg,
  col_sum_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(NUM_COLS - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_col;

  assign state_dbg = r_state;

`ifdef COL_SUM_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_err;

  assign err = r_err;
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (TIMEOUT == 0);
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state         <= IDLE;
      r_col           <= '0;
      busy            <= 1'b0;
      sweep_done      <= 1'b0;
      bus.msg_rd_en   <= 1'b0;
      bus.msg_rd_addr <= '0;
      bus.add_r1      <= '0;
      bus.add_r2      <= '0;
      bus.add_r3      <= '0;
      bus.add_start   <= 1'b0;
      bus.res_wr_en   <= 1'b0;
      bus.res_wr_addr <= '0;
      bus.res_wr_data <= '0;
`ifdef COL_SUM_TIMEOUT_EN
      r_wd_cnt        <= '0;
      r_err           <= 1'b0;
`endif
    end else begin
      // Strobes default low so each is a single-cycle pulse.
      bus.msg_rd_en <= 1'b0;
      bus.add_start <= 1'b0;
      bus.res_wr_en <= 1'b0;
      sweep_done    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (go) begin
            r_col           <= '0;
            busy            <= 1'b1;
            bus.msg_rd_en   <= 1'b1;
            bus.msg_rd_addr <= '0;
`ifdef COL_SUM_TIMEOUT_EN
            r_err           <= 1'b0;
`endif
            r_state         <= FETCH;
          end
        end
        FETCH: r_state <= WAIT_RD;
        WAIT_RD: begin
          bus.add_r1    <= bus.msg_rd_data[R1_LSB +: DATA_W];
          bus.add_r2    <= bus.msg_rd_data[R2_LSB +: DATA_W];
          bus.add_r3    <= bus.msg_rd_data[R3_LSB +: DATA_W];
          bus.add_start <= 1'b1;
          r_state       <= LAUNCH;
        end
        LAUNCH: begin
`ifdef COL_SUM_TIMEOUT_EN
          r_wd_cnt <= '0;
`endif
          r_state  <= WAIT_ADD;
        end
        WAIT_ADD: begin
          if (bus.add_done) begin
            bus.res_wr_data <= bus.add_sum;
            bus.res_wr_en   <= 1'b1;
            bus.res_wr_addr <= r_col;
            r_state         <= WRITE;
          end
`ifdef COL_SUM_TIMEOUT_EN
          else if (r_wd_cnt == WD_LAST) begin
            bus.res_wr_data <= FLOAT_QNAN;
            bus.res_wr_en   <= 1'b1;
            bus.res_wr_addr <= r_col;
            r_err           <= 1'b1;
            r_state         <= WRITE;
          end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
          end
`endif
        end
        WRITE: begin
          if (r_col == LAST_COL) begin
            busy       <= 1'b0;
            sweep_done <= 1'b1;
            r_state    <= DONE;
          end else begin
            r_col           <= r_col + 1'b1;
            bus.msg_rd_en   <= 1'b1;
            bus.msg_rd_addr <= r_col + 1'b1;
            r_state         <= FETCH;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_column_sum_scheduler.sv
// Bench for column_sum_scheduler: directed float vectors, random sweeps, reset abort,
// and (when COL_SUM_TIMEOUT_EN is defined) the adder watchdog.
module tb_column_sum_scheduler;
  import col_sum_pkg::*;

  localparam int AW = 3;
  localparam int NC = 8;
  localparam int TO = 16;
  localparam int W  = AW + DATA_W;

  typedef struct {
    logic [95:0] ops;  // {r3, r2, r1}
    logic [31:0] sum;
  } vec_t;

  vec_t tbl[9];

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic clr_n = 1'b0;
  int   cyc   = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT A: eight columns ----------------
  logic   go_a = 1'b0;
  logic   busy_a, done_a, err_a;
  state_t st_a;
  col_sum_if #(.ADDR_W(AW)) bus_a();

  column_sum_scheduler #(.NUM_COLS(NC), .ADDR_W(AW), .TIMEOUT(TO)) dut_a (
    .clk(clk), .clr_n(clr_n), .go(go_a), .busy(busy_a), .sweep_done(done_a),
    .err(err_a), .state_dbg(st_a), .bus(bus_a)
  );

  // ---------------- DUT B: single column ----------------
  logic   go_b = 1'b0;
  logic   busy_b, done_b, err_b;
  state_t st_b;
  col_sum_if #(.ADDR_W(AW)) bus_b();

  column_sum_scheduler #(.NUM_COLS(1), .ADDR_W(AW), .TIMEOUT(TO)) dut_b (
    .clk(clk), .clr_n(clr_n), .go(go_b), .busy(busy_b), .sweep_done(done_b),
    .err(err_b), .state_dbg(st_b), .bus(bus_b)
  );

  task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Adder reference: known float triples from the table, otherwise a plain integer sum.
  function automatic logic [31:0] add_model(input logic [95:0] ops);
    for (int i = 0; i < 9; i++) if (tbl[i].ops == ops) return tbl[i].sum;
    return ops[31:0] + ops[63:32] + ops[95:64];
  endfunction

  function automatic logic [159:0] outs_a();
    return 160'({busy_a, done_a, err_a, st_a, bus_a.msg_rd_en, bus_a.msg_rd_addr,
                 bus_a.add_r3, bus_a.add_r2, bus_a.add_r1, bus_a.add_start,
                 bus_a.res_wr_en, bus_a.res_wr_addr, bus_a.res_wr_data});
  endfunction

  function automatic logic [159:0] outs_b();
    return 160'({busy_b, done_b, err_b, st_b, bus_b.msg_rd_en, bus_b.msg_rd_addr,
                 bus_b.add_r3, bus_b.add_r2, bus_b.add_r1, bus_b.add_start,
                 bus_b.res_wr_en, bus_b.res_wr_addr, bus_b.res_wr_data});
  endfunction

  // ---------------- environment A: RAM + adder ----------------
  logic [95:0] ram_a[NC];
  int          lat_a    = 3;
  int          stall_a  = -1;
  bit          glitch_a = 1'b0;
  int          cnt_a;
  bit          gl_a, fire_a, gl_next_a;
  logic [95:0] opnd_a;

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      bus_a.msg_rd_data <= '0;
      bus_a.add_done    <= 1'b0;
      bus_a.add_sum     <= '0;
      cnt_a = 0;
      gl_a  = 1'b0;
    end else begin
      if (bus_a.msg_rd_en) bus_a.msg_rd_data <= ram_a[bus_a.msg_rd_addr];
      fire_a = 1'b0;
      if (bus_a.add_start && int'(bus_a.msg_rd_addr) != stall_a) begin
        cnt_a  = lat_a;
        opnd_a = {bus_a.add_r3, bus_a.add_r2, bus_a.add_r1};
      end
      if (cnt_a > 0) begin
        cnt_a--;
        fire_a = (cnt_a == 0);
      end
      gl_next_a = glitch_a && bus_a.add_done && !gl_a;
      gl_a      = gl_next_a;
      bus_a.add_done <= fire_a || gl_next_a;
      if (fire_a) bus_a.add_sum <= add_model(opnd_a);
      else if (gl_next_a) bus_a.add_sum <= 32'hDEADBEEF;
    end
  end

  // ---------------- environment B: RAM + adder (latency 3) ----------------
  logic [95:0] ram_b;
  int          cnt_b;
  logic [95:0] opnd_b;

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      bus_b.msg_rd_data <= '0;
      bus_b.add_done    <= 1'b0;
      bus_b.add_sum     <= '0;
      cnt_b = 0;
    end else begin
      if (bus_b.msg_rd_en) bus_b.msg_rd_data <= ram_b;
      bus_b.add_done <= 1'b0;
      if (bus_b.add_start) begin
        cnt_b  = 3;
        opnd_b = {bus_b.add_r3, bus_b.add_r2, bus_b.add_r1};
      end
      if (cnt_b > 0) begin
        cnt_b--;
        if (cnt_b == 0) begin
          bus_b.add_done <= 1'b1;
          bus_b.add_sum  <= add_model(opnd_b);
        end
      end
    end
  end

  // ---------------- scoreboard / monitor A ----------------
  logic [W-1:0] exp_q[$];
  int rd_cyc_a, start_tot_a, wr_tot_a, done_tot_a, done_cyc_a, fetch_cyc_a;
  int start_base_a, wr_base_a;
  bit busy_prev_a;

  always @(negedge clk) begin
    if (bus_a.msg_rd_en) rd_cyc_a = cyc;
    if (bus_a.add_start) begin
      check("start_after_rd", 160'(cyc - rd_cyc_a), 160'(2));
      if (start_tot_a - start_base_a < NC)
        check("operands", 160'({bus_a.add_r3, bus_a.add_r2, bus_a.add_r1}),
              160'(ram_a[start_tot_a - start_base_a]));
      start_tot_a++;
    end
    if (bus_a.res_wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %0h expected no write",
                 bus_a.res_wr_addr, bus_a.res_wr_data);
      end else begin
        check("write", 160'({bus_a.res_wr_addr, bus_a.res_wr_data}), 160'(exp_q.pop_front()));
      end
      check("err_flag", 160'(err_a), 160'(stall_a >= 0 && (wr_tot_a - wr_base_a) >= stall_a));
      wr_tot_a++;
    end
    if (done_a) begin
      done_tot_a++;
      done_cyc_a = cyc;
    end
    if (busy_a && !busy_prev_a) fetch_cyc_a = cyc;
    busy_prev_a = busy_a;
  end

  // ---------------- driver tasks ----------------
  task automatic arm_a(input int lat, input bit glitch, input int stall, input bit use_tbl,
                       output int exp_cyc);
    logic [31:0] s;
    lat_a = lat;
    glitch_a = glitch;
    stall_a = stall;
    start_base_a = start_tot_a;
    wr_base_a = wr_tot_a;
    exp_cyc = 1;
    for (int c = 0; c < NC; c++) begin
      s = use_tbl ? tbl[c].sum : add_model(ram_a[c]);
      if (c == stall) s = FLOAT_QNAN;
      exp_q.push_back({AW'(c), s});
      exp_cyc += 4 + ((c == stall) ? TO : lat);
    end
  endtask

  task automatic pulse_go_a();
    @(posedge clk); #1 go_a = 1'b1;
    @(posedge clk); #1 go_a = 1'b0;
  endtask

  task automatic run_sweep_a(input int lat, input bit use_tbl, input bit glitch,
                             input bit go_mid, input int stall);
    int exp_cyc, d0;
    bit went, seen;
    arm_a(lat, glitch, stall, use_tbl, exp_cyc);
    d0 = done_tot_a;
    pulse_go_a();
    went = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(posedge clk); #1;
      go_a = 1'b0;
      if (done_tot_a > d0) seen = 1'b1;
      else if (go_mid && !went && st_a == WAIT_ADD) begin
        go_a = 1'b1;
        went = 1'b1;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL sweep_timeout: got no sweep_done expected one within 3000 cycles");
    end
    repeat (6) @(posedge clk);
    #1;
    check("done_count", 160'(done_tot_a - d0), 160'(1));
    check("queue_empty", 160'(exp_q.size()), 160'(0));
    check("idle_after", 160'({busy_a, st_a}), 160'({1'b0, IDLE}));
    check("sweep_cycles", 160'(done_cyc_a - fetch_cyc_a + 1), 160'(exp_cyc));
    exp_q.delete();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int rdc, stc, nw, nd, dummy;
    logic [AW-1:0] wa;
    logic [31:0]   wd;
    bit hit;

    tbl[0] = '{{32'h40400000, 32'h40000000, 32'h3F800000}, 32'h40C00000};  // 1+2+3
    tbl[1] = '{{32'h3E800000, 32'h3E800000, 32'h3F000000}, 32'h3F800000};  // .5+.25+.25
    tbl[2] = '{{32'h41000000, 32'h40800000, 32'h40800000}, 32'h41800000};  // 4+4+8
    tbl[3] = '{{32'hBF800000, 32'h40200000, 32'h3FC00000}, 32'h40400000};  // 1.5+2.5-1
    tbl[4] = '{{32'h41F00000, 32'h41A00000, 32'h41200000}, 32'h42700000};  // 10+20+30
    tbl[5] = '{{32'hC0800000, 32'hC0000000, 32'hC0000000}, 32'hC1000000};  // -2-2-4
    tbl[6] = '{{32'h00000000, 32'h00000000, 32'h00000000}, 32'h00000000};  // 0+0+0
    tbl[7] = '{{32'h3F000000, 32'h3F000000, 32'h42C80000}, 32'h42CA0000};  // 100+.5+.5
    tbl[8] = '{{32'h40FCCCCD, 32'h4019999A, 32'h3F99999A}, 32'h41380000};  // 1.2+2.4+7.9
    for (int c = 0; c < NC; c++) ram_a[c] = '0;
    ram_b = '0;

    // Test 1: reset values, then idle with go low
    repeat (3) @(posedge clk);
    #1 check("reset_outs_a", outs_a(), 160'(0));
    check("reset_outs_b", outs_b(), 160'(0));
    clr_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_outs_a", outs_a(), 160'(0));
    end
    check("idle_outs_b", outs_b(), 160'(0));

    // Test 2: single-column sweep on DUT B
    ram_b = tbl[8].ops;
    @(posedge clk); #1 go_b = 1'b1;
    @(posedge clk); #1 go_b = 1'b0;
    rdc = -100; stc = 0; nw = 0; nd = 0; wa = '1; wd = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_b.msg_rd_en) rdc = cyc;
      if (bus_b.add_start) stc = cyc;
      if (bus_b.res_wr_en) begin
        nw++;
        wa = bus_b.res_wr_addr;
        wd = bus_b.res_wr_data;
      end
      if (done_b) nd++;
    end
    check("b_start_lat", 160'(stc - rdc), 160'(2));
    check("b_writes", 160'(nw), 160'(1));
    check("b_wr_addr", 160'(wa), 160'(0));
    check("b_wr_data", 160'(wd), 160'(32'h41380000));
    check("b_done", 160'(nd), 160'(1));
    check("b_idle", 160'({busy_b, st_b}), 160'({1'b0, IDLE}));

    // Test 3: eight-column sweep over the float table
    for (int c = 0; c < NC; c++) ram_a[c] = tbl[c].ops;
    run_sweep_a(3, 1'b1, 1'b0, 1'b0, -1);
    check("operands_hold", 160'({bus_a.add_r3, bus_a.add_r2, bus_a.add_r1}), 160'(tbl[NC-1].ops));
    check("rd_addr_hold", 160'(bus_a.msg_rd_addr), 160'(NC - 1));

    // Test 4: go during WAIT_ADD and add_done glitch during WRITE
    run_sweep_a(2, 1'b1, 1'b1, 1'b1, -1);

    // Random sweeps with random data and adder latency
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < NC; c++) ram_a[c] = {$urandom, $urandom, $urandom};
      run_sweep_a($urandom_range(1, 6), 1'b0, 1'b0, 1'b0, -1);
    end

    // Test 5: asynchronous reset during column 3's WAIT_ADD
    arm_a(3, 1'b0, -1, 1'b0, dummy);
    nd = done_tot_a;
    pulse_go_a();
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk);
      if ((wr_tot_a - wr_base_a) == 3 && st_a == WAIT_ADD) hit = 1'b1;
    end
    check("reached_col3_wait", 160'(hit), 160'(1));
    #2 clr_n = 1'b0;
    #1 check("abort_outs_a", outs_a(), 160'(0));
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 check("abort_hold_a", outs_a(), 160'(0));
    check("abort_no_done", 160'(done_tot_a - nd), 160'(0));
    clr_n = 1'b1;
    run_sweep_a(3, 1'b0, 1'b0, 1'b0, -1);

`ifdef COL_SUM_TIMEOUT_EN
    // Test 6: adder never answers column 2
    for (int c = 0; c < NC; c++) ram_a[c] = {$urandom, $urandom, $urandom};
    run_sweep_a(3, 1'b0, 1'b0, 1'b0, 2);
    check("err_sticky", 160'(err_a), 160'(1));
    run_sweep_a(2, 1'b0, 1'b0, 1'b0, -1);
    check("err_cleared", 160'(err_a), 160'(0));
`else
    check("err_tied_low", 160'({err_a, err_b}), 160'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
